// File: rtl/regfile_sb.sv
// regfile_sb: register file with a per-register pending-result scoreboard.
//   - NUM_REGS = 2**ADDR_W registers of DATA_W bits, one write-back port,
//     two combinational read ports.
//   - Each register has a busy bit. An issue sets it and a write-back clears it.
//     When both target the same register in one cycle, the issue wins.
//   - rst is asynchronous and active-high. It clears all data and busy state at once.
//   - Optional macro REGFILE_BYPASS_EN adds same-cycle forwarding of wb_data
//     to the read ports and masks the busy flag being cleared by that write-back.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    localparam int NUM_REGS = 2**ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   src1,
    input  logic [ADDR_W-1:0]   src2,
    input  logic                wb_en,
    input  logic [ADDR_W-1:0]   wb_dest,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic                iss_en,
    input  logic [ADDR_W-1:0]   iss_dest,
    output logic [DATA_W-1:0]   reg1,
    output logic [DATA_W-1:0]   reg2,
    output logic                busy1,
    output logic                busy2,
    output logic                hazard,
    output logic [NUM_REGS-1:0] busy_vec
);

    // Flattened view of the storage and scoreboard, one slice per register
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
    logic [NUM_REGS-1:0]             busy_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_W-1:0] data_reg;
            logic              busy_reg;
            logic              wb_hit;
            logic              iss_hit;

            assign wb_hit  = wb_en  && (wb_dest  == ADDR_W'(gi));
            assign iss_hit = iss_en && (iss_dest == ADDR_W'(gi));

            // Data storage: capture the write-back value when this register is the target
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_reg <= '0;
                end else if (wb_hit) begin
                    data_reg <= wb_data;
                end
            end

            // Scoreboard bit: an issue sets it, a write-back clears it, and an issue beats a write-back
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    busy_reg <= 1'b0;
                end else if (iss_hit) begin
                    busy_reg <= 1'b1;
                end else if (wb_hit) begin
                    busy_reg <= 1'b0;
                end
            end

            assign regs_q[gi] = data_reg;
            assign busy_q[gi] = busy_reg;
        end
    endgenerate

    logic fwd1;
    logic fwd2;
    logic reiss1;
    logic reiss2;

    // Read ports: zero-latency lookup, optional forwarding, forced to zero while in reset
    always_comb begin
        fwd1   = wb_en  && (wb_dest  == src1);
        fwd2   = wb_en  && (wb_dest  == src2);
        reiss1 = iss_en && (iss_dest == src1);
        reiss2 = iss_en && (iss_dest == src2);
        reg1   = regs_q[src1];
        reg2   = regs_q[src2];
        busy1  = busy_q[src1];
        busy2  = busy_q[src2];
`ifdef REGFILE_BYPASS_EN
        if (fwd1) begin
            reg1 = wb_data;
        end
        if (fwd2) begin
            reg2 = wb_data;
        end
        // The result arriving this cycle is no longer pending, unless a new producer re-claims the register
        if (fwd1 && !reiss1) begin
            busy1 = 1'b0;
        end
        if (fwd2 && !reiss2) begin
            busy2 = 1'b0;
        end
`else
        // Without forwarding, the match terms do not affect the outputs
        if (fwd1 && fwd2 && reiss1 && reiss2) begin
            busy1 = busy_q[src1];
        end
`endif
        if (rst) begin
            reg1  = '0;
            reg2  = '0;
            busy1 = 1'b0;
            busy2 = 1'b0;
        end
        hazard   = busy1 | busy2;
        busy_vec = rst ? '0 : busy_q;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: testbench for regfile_sb.
// It drives directed scenarios, then randomized traffic with occasional asynchronous resets.
// A behavioural model (an array of values plus a busy mask) is checked against every
// output on every falling edge. A second 16x8 instance covers the parameter overrides.
module tb_regfile_sb;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NR = 16;

    logic          clk;
    logic          rst;
    logic [AW-1:0] src1, src2, wb_dest, iss_dest;
    logic          wb_en, iss_en;
    logic [DW-1:0] wb_data;
    logic [DW-1:0] reg1, reg2;
    logic          busy1, busy2, hazard;
    logic [NR-1:0] busy_vec;

    // Second instance with DATA_W=16, ADDR_W=3
    logic          rst16;
    logic [2:0]    s1_16, s2_16, wbd_16, isd_16;
    logic          wbe_16, ise_16;
    logic [15:0]   wbdat_16, r1_16, r2_16;
    logic          b1_16, b2_16, hz_16;
    logic [7:0]    bv_16;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    // Reference model
    logic [DW-1:0] m_regs [NR];
    logic [NR-1:0] m_busy;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
        .iss_en(iss_en), .iss_dest(iss_dest),
        .reg1(reg1), .reg2(reg2), .busy1(busy1), .busy2(busy2),
        .hazard(hazard), .busy_vec(busy_vec)
    );

    regfile_sb #(.DATA_W(16), .ADDR_W(3)) dut16 (
        .clk(clk), .rst(rst16), .src1(s1_16), .src2(s2_16),
        .wb_en(wbe_16), .wb_dest(wbd_16), .wb_data(wbdat_16),
        .iss_en(ise_16), .iss_dest(isd_16),
        .reg1(r1_16), .reg2(r2_16), .busy1(b1_16), .busy2(b2_16),
        .hazard(hz_16), .busy_vec(bv_16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_busy = '0;
    endtask

    // Expected read data for one port, from the stored values and the current inputs
    function automatic logic [DW-1:0] exp_reg(input logic [AW-1:0] s);
        if (rst) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wb_en && wb_dest == s) return wb_data;
`endif
        return m_regs[s];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] s);
        if (rst) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (wb_en && wb_dest == s && !(iss_en && iss_dest == s)) return 1'b0;
`endif
        return m_busy[s];
    endfunction

    // Compare process: all outputs against the model on every falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("reg1", reg1, exp_reg(src1));
            check("reg2", reg2, exp_reg(src2));
            check("busy1", busy1, exp_busy(src1));
            check("busy2", busy2, exp_busy(src2));
            check("hazard", hazard, exp_busy(src1) | exp_busy(src2));
            check("busy_vec", busy_vec, rst ? 16'h0 : m_busy);
            $display("cyc t=%0t rst=%0d wb=%0d/%0d/%h iss=%0d/%0d src=%0d,%0d reg1=%h reg2=%h bv=%h",
                     $time, rst, wb_en, wb_dest, wb_data, iss_en, iss_dest, src1, src2, reg1, reg2, busy_vec);
        end
    end

    // Advance one rising edge. Apply the model update for that edge, then settle
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            if (wb_en) begin
                m_regs[wb_dest] = wb_data;
                m_busy[wb_dest] = 1'b0;
            end
            if (iss_en) m_busy[iss_dest] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        wb_en = 0; iss_en = 0;
    endtask

    task automatic do_wb(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb_en = 1; wb_dest = a; wb_data = d;
        tick();
        wb_en = 0;
    endtask

    initial begin
        rst = 1; src1 = 0; src2 = 0; wb_en = 0; wb_dest = 0; wb_data = 0;
        iss_en = 0; iss_dest = 0;
        rst16 = 1; s1_16 = 0; s2_16 = 0; wbe_16 = 0; wbd_16 = 0; wbdat_16 = 0;
        ise_16 = 0; isd_16 = 0;
        model_clear();
        chk_en = 1;
        #2;
        check("reset_reg1", reg1, 32'h0);
        check("reset_busy_vec", busy_vec, 16'h0);
        check("reset_hazard", hazard, 1'b0);
        @(negedge clk); #1;
        rst = 0; rst16 = 0;

        // Write/read, including a full-width value
        do_wb(5, 32'h12345678);
        src1 = 5; src2 = 5; #1;
        check("wr5_reg1", reg1, 32'h12345678);
        check("wr5_reg2", reg2, 32'h12345678);
        check("wr5_model", m_regs[5], 32'h12345678);
        do_wb(15, 32'hFFFFFFFF);
        src1 = 15; #1;
        check("wr15_reg1", reg1, 32'hFFFFFFFF);

        // Scoreboard set and clear
        iss_en = 1; iss_dest = 7; tick(); iss_en = 0;
        src1 = 7; src2 = 0; #1;
        check("sb_busy1", busy1, 1'b1);
        check("sb_hazard", hazard, 1'b1);
        check("sb_busy_vec", busy_vec, 16'h0080);
        check("sb_model", m_busy, 16'h0080);
        do_wb(7, 32'h77);
        check("sb_clr_busy1", busy1, 1'b0);
        check("sb_clr_hazard", hazard, 1'b0);

        // Issue and write-back to the same busy register in one cycle
        iss_en = 1; iss_dest = 2; tick();
        iss_en = 1; iss_dest = 2; wb_en = 1; wb_dest = 2; wb_data = 32'hA5; tick(); idle();
        src1 = 2; #1;
        check("coll_reg", reg1, 32'hA5);
        check("coll_busy", busy_vec[2], 1'b1);
        check("coll_model", m_busy[2], 1'b1);
        do_wb(2, 32'hA6);
        // Issue to an already-busy register, then a write-back to a non-busy one
        iss_en = 1; iss_dest = 9; tick(); tick(); iss_en = 0;
        check("reissue_busy", busy_vec, 16'h0200);
        do_wb(10, 32'hCAFE);
        check("wb_nonbusy", busy_vec, 16'h0200);
        do_wb(9, 32'h9);

        // Write-back before the edge: forwarded or stored value
        do_wb(4, 32'h11);
        wb_en = 1; wb_dest = 4; wb_data = 32'h22; src2 = 4; #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_reg2", reg2, 32'h22);
`else
        check("byp_reg2", reg2, 32'h11);
`endif
        check("byp_busy2", busy2, 1'b0);
        tick(); idle();

        // Asynchronous reset between edges
        do_wb(3, 32'hDEADBEEF);
        iss_en = 1; iss_dest = 6; tick(); idle();
        src1 = 3; #2;
        rst = 1; model_clear(); #1;
        check("arst_reg1", reg1, 32'h0);
        check("arst_busy_vec", busy_vec, 16'h0);
        iss_en = 1; iss_dest = 1; wb_en = 1; wb_dest = 3; wb_data = 32'h5; tick();
        check("arst_ignored", busy_vec, 16'h0);
        rst = 0; tick(); idle();
        check("post_rst_edge", busy_vec, 16'h0002);

        // Randomized traffic with occasional mid-cycle resets
        for (int n = 0; n < 600; n++) begin
            src1     = AW'($urandom);
            src2     = ($urandom_range(0, 3) == 0) ? src1 : AW'($urandom);
            wb_en    = $urandom_range(0, 1) == 1;
            wb_dest  = ($urandom_range(0, 2) == 0) ? src1 : AW'($urandom);
            wb_data  = $urandom;
            iss_en   = $urandom_range(0, 2) == 0;
            iss_dest = ($urandom_range(0, 3) == 0) ? wb_dest : AW'($urandom);
            if ($urandom_range(0, 40) == 0) begin
                rst = 1; model_clear();
            end else begin
                rst = 0;
            end
            tick();
        end
        rst = 0; idle(); tick();

        // Parameter override instance: 8 entries, 16-bit data
        wbe_16 = 1; wbd_16 = 7; wbdat_16 = 16'hBEEF; ise_16 = 1; isd_16 = 5;
        @(posedge clk); #1;
        wbe_16 = 0; ise_16 = 0; s1_16 = 7; s2_16 = 5; #1;
        check("p16_reg1", r1_16, 16'hBEEF);
        check("p16_busy_vec", bv_16, 8'h20);
        check("p16_hazard", hz_16, 1'b1);

        chk_en = 0;
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, default 32, register data width in bits.
REQ-002 Parameter ADDR_W, default 4, register index width; NUM_REGS = 2**ADDR_W entries.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 src1  input  ADDR_W  read port 1 index.
REQ-006 src2  input  ADDR_W  read port 2 index.
REQ-007 wb_en  input  1  write-back enable.
REQ-008 wb_dest  input  ADDR_W  write-back destination index.
REQ-009 wb_data  input  DATA_W  write-back data.
REQ-010 iss_en  input  1  issue strobe; marks iss_dest as pending.
REQ-011 iss_dest  input  ADDR_W  destination index of the issuing instruction.
REQ-012 reg1  output  DATA_W  read data, port 1.
REQ-013 reg2  output  DATA_W  read data, port 2.
REQ-014 busy1  output  1  src1 has a pending, unwritten result.
REQ-015 busy2  output  1  src2 has a pending, unwritten result.
REQ-016 hazard  output  1  busy1 OR busy2.
REQ-017 busy_vec  output  NUM_REGS  scoreboard bits; bit i = register i pending.

Function
REQ-018 Storage SHALL be NUM_REGS x DATA_W; every register SHALL be DATA_W wide (no truncation of wb_data).
REQ-019 When wb_en=1, regs[wb_dest] SHALL take wb_data at the rising edge; when wb_en=0, no register SHALL change.
REQ-020 reg1/reg2 SHALL be combinational reads of regs[src1]/regs[src2], zero-cycle latency.
REQ-021 Busy set: iss_en=1 SHALL set busy_vec[iss_dest] at the rising edge.
REQ-022 Busy clear: wb_en=1 SHALL clear busy_vec[wb_dest] at the rising edge.
REQ-023 iss_en and wb_en in the same cycle with iss_dest==wb_dest: data SHALL be written AND busy bit SHALL end set (new producer wins).
REQ-024 iss_en and wb_en in the same cycle to different indices: both updates SHALL apply independently.
REQ-025 iss_en to an already-busy index SHALL leave it set (no counting; single outstanding producer per register).
REQ-026 wb_en to a non-busy index SHALL write data and leave the busy bit clear.
REQ-027 busy1 = busy_vec[src1], busy2 = busy_vec[src2], combinational, subject to REQ-035.
REQ-028 src1==src2 SHALL return identical data and busy values on both ports.

Reset
REQ-029 rst=1 SHALL immediately, without a clock edge, clear all registers to 0 and all busy_vec bits to 0.
REQ-030 While rst=1, writes and issues SHALL be ignored; reg1, reg2 = 0, busy1, busy2, hazard = 0, busy_vec = 0.
REQ-031 Reset asserted mid-operation SHALL discard all pending busy state; the first edge after rst deasserts SHALL process inputs normally.

Configuration
REQ-032 Macro REGFILE_BYPASS_EN SHALL select same-cycle write-to-read forwarding.
REQ-033 Defined: if wb_en=1 and wb_dest==srcN, regN SHALL equal wb_data in that cycle.
REQ-034 Not defined: regN SHALL return the stored (pre-write) value until after the edge.
REQ-035 Defined: busyN SHALL be 0 when wb_en=1 and wb_dest==srcN, unless iss_en=1 and iss_dest==srcN in the same cycle; not defined: busyN follows busy_vec only.

Verification
REQ-036 Reset: write regs[3]=0xDEADBEEF, assert rst between edges -> reg1 (src1=3) = 0 at once, busy_vec = 0.
REQ-037 Write/read: wb_en, wb_dest=5, wb_data=0x12345678, one edge; src1=src2=5 -> reg1=reg2=0x12345678; wb_dest=15 with 0xFFFFFFFF -> full 32 bits read back.
REQ-038 Scoreboard: iss_en, iss_dest=7; next cycle src1=7 -> busy1=1, hazard=1, busy_vec=0x0080; wb_en, wb_dest=7 edge -> busy1=0, hazard=0.
REQ-039 Collision: busy[2]=1, same cycle iss_en/iss_dest=2 and wb_en/wb_dest=2/0xA5 -> after edge regs[2]=0xA5, busy_vec[2]=1.
REQ-040 Bypass: regs[4]=0x11, drive wb_en, wb_dest=4, wb_data=0x22, src2=4 pre-edge -> reg2=0x22, busy2=0 with REGFILE_BYPASS_EN; reg2=0x11 without.
REQ-041 Parameters: DATA_W=16, ADDR_W=3 -> 8 entries, busy_vec 8 bits, write 0xBEEF to index 7 reads back 0xBEEF.
